// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU codes, byte enables, bundle control struct.
package riscv_pkg;

  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcOp32    = 7'b0111011;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0101;
  localparam logic [3:0] AluNop  = 4'b1010;
  localparam logic [3:0] AluSlt  = 4'b1011;
  localparam logic [3:0] AluSltu = 4'b1100;
  localparam logic [3:0] AluSll  = 4'b1101;
  localparam logic [3:0] AluSrl  = 4'b1110;
  localparam logic [3:0] AluSra  = 4'b1111;

  localparam logic [7:0] BeByte   = 8'h01;
  localparam logic [7:0] BeHalf   = 8'h03;
  localparam logic [7:0] BeWord   = 8'h0F;
  localparam logic [7:0] BeDouble = 8'hFF;

  typedef enum logic [2:0] {FmtNone, FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

  // Width-independent part of the decoded bundle.
  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] rd;
    logic       we_regs;
    logic       we_mem;
    logic       is_load;
    logic       is_jalr;
    logic       is_jal;
    logic       is_branch;
    logic       is_word;
    logic       illegal;
    logic [2:0] func3;
    logic [7:0] be;
  } ctrl_t;

  // Access size is func3[1:0] for both loads and stores.
  function automatic logic [7:0] be_for_size(input logic [1:0] size);
    case (size)
      2'b00:   return BeByte;
      2'b01:   return BeHalf;
      2'b10:   return BeWord;
      default: return BeDouble;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: classifies the instruction format and builds the sign-extended immediate.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt
);

  logic [31:0] imm32;

  // Format from opcode, then the 32-bit immediate for that format.
  always_comb begin
    case (instr[6:0])
      OpcOp, OpcOp32:                        fmt = FmtR;
      OpcLoad, OpcOpImm, OpcOpImm32, OpcJalr: fmt = FmtI;
      OpcStore:                              fmt = FmtS;
      OpcBranch:                             fmt = FmtB;
      OpcLui, OpcAuipc:                      fmt = FmtU;
      OpcJal:                                fmt = FmtJ;
      default:                               fmt = FmtNone;
    endcase
    case (fmt)
      FmtI:    imm32 = {{20{instr[31]}}, instr[31:20]};
      FmtS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FmtB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FmtU:    imm32 = {instr[31:12], 12'b0};
      FmtJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // Every format sign-extends from bit 31 of the 32-bit form.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute with load-use stall and flush.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter bit          EN_WORD_OPS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_we_regs,
  output logic            out_we_mem,
  output logic            out_is_load,
  output logic            out_is_jalr,
  output logic            out_is_jal,
  output logic            out_is_branch,
  output logic            out_is_word,
  output logic            out_illegal,
  output logic [2:0]      out_func3,
  output logic [7:0]      out_be
);

  // Word ops only exist on RV64.
  localparam bit WordEn = EN_WORD_OPS && (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] rs2_val;
    ctrl_t           ctrl;
  } bundle_t;

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd_f;
  logic [XLEN-1:0] imm;
  fmt_e            fmt;
  logic            sh_lo, sh_ar;
  logic            use_rs1, use_rs2, use_imm, a_pc, bad, hazard, advance;
  ctrl_t           ctrl;
  bundle_t         bundle_d, bundle_q;
  logic            out_valid_q;

  assign opcode = in_instr[6:0];
  assign rd_f   = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm   (imm),
    .fmt   (fmt)
  );

  // RV64 immediate shifts use a 6-bit shamt, so only instr[31:26] selects the variant.
  assign sh_lo = (XLEN == 64) ? (in_instr[31:26] == 6'b000000) : (f7 == 7'b0000000);
  assign sh_ar = (XLEN == 64) ? (in_instr[31:26] == 6'b010000) : (f7 == 7'b0100000);

  assign use_rs1 = fmt inside {FmtR, FmtI, FmtS, FmtB};
  assign use_rs2 = fmt inside {FmtR, FmtS, FmtB};
  assign rs1     = use_rs1 ? in_instr[19:15] : 5'd0;
  assign rs2     = use_rs2 ? in_instr[24:20] : 5'd0;

  // Unused source fields read as 0, which never matches a nonzero load destination.
  assign hazard  = out_valid_q && bundle_q.ctrl.is_load && (bundle_q.ctrl.rd != 5'd0) &&
                   ((bundle_q.ctrl.rd == rs1) || (bundle_q.ctrl.rd == rs2));
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && !hazard && !flush;

  // Field decode and legality; an illegal word collapses to a NOP carrying only the flag.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = AluNop;
    ctrl.rd     = rd_f;
    ctrl.func3  = f3;
    use_imm     = 1'b0;
    a_pc        = 1'b0;
    bad         = 1'b0;
    case (opcode)
      OpcLui: begin
        ctrl.alu_op = AluAdd; ctrl.we_regs = 1'b1; use_imm = 1'b1;
      end
      OpcAuipc: begin
        // Operand A is the pc so execute needs no AUIPC flag.
        ctrl.alu_op = AluAdd; ctrl.we_regs = 1'b1; use_imm = 1'b1; a_pc = 1'b1;
      end
      OpcJal: begin
        ctrl.alu_op = AluAdd; ctrl.we_regs = 1'b1; ctrl.is_jal = 1'b1; use_imm = 1'b1;
      end
      OpcJalr: begin
        ctrl.alu_op = AluAdd; ctrl.we_regs = 1'b1; ctrl.is_jalr = 1'b1; use_imm = 1'b1;
        bad = (f3 != 3'b000);
      end
      OpcBranch: begin
        ctrl.alu_op = AluAdd; ctrl.is_branch = 1'b1; ctrl.rd = 5'd0;
        bad = (f3[2:1] == 2'b01);
      end
      OpcLoad: begin
        ctrl.alu_op = AluAdd; ctrl.we_regs = 1'b1; ctrl.is_load = 1'b1; use_imm = 1'b1;
        ctrl.be = be_for_size(f3[1:0]);
        bad = (f3 == 3'b111) || (!WordEn && ((f3 == 3'b011) || (f3 == 3'b110)));
      end
      OpcStore: begin
        ctrl.alu_op = AluAdd; ctrl.we_mem = 1'b1; ctrl.rd = 5'd0; use_imm = 1'b1;
        ctrl.be = be_for_size(f3[1:0]);
        bad = f3[2] || (!WordEn && (f3 == 3'b011));
      end
      OpcOpImm: begin
        ctrl.we_regs = 1'b1; use_imm = 1'b1;
        case (f3)
          3'b000: ctrl.alu_op = AluAdd;
          3'b010: ctrl.alu_op = AluSlt;
          3'b011: ctrl.alu_op = AluSltu;
          3'b100: ctrl.alu_op = AluXor;
          3'b110: ctrl.alu_op = AluOr;
          3'b111: ctrl.alu_op = AluAnd;
          3'b001: begin ctrl.alu_op = AluSll; bad = !sh_lo; end
          default: begin
            ctrl.alu_op = sh_ar ? AluSra : AluSrl;
            bad = !sh_lo && !sh_ar;
          end
        endcase
      end
      OpcOp: begin
        ctrl.we_regs = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: ctrl.alu_op = AluAdd;
          {7'h20, 3'b000}: ctrl.alu_op = AluSub;
          {7'h00, 3'b001}: ctrl.alu_op = AluSll;
          {7'h00, 3'b010}: ctrl.alu_op = AluSlt;
          {7'h00, 3'b011}: ctrl.alu_op = AluSltu;
          {7'h00, 3'b100}: ctrl.alu_op = AluXor;
          {7'h00, 3'b101}: ctrl.alu_op = AluSrl;
          {7'h20, 3'b101}: ctrl.alu_op = AluSra;
          {7'h00, 3'b110}: ctrl.alu_op = AluOr;
          {7'h00, 3'b111}: ctrl.alu_op = AluAnd;
          default:         bad = 1'b1;
        endcase
      end
      OpcOpImm32: begin
        ctrl.we_regs = 1'b1; ctrl.is_word = 1'b1; use_imm = 1'b1; bad = !WordEn;
        case ({f7, f3}) inside
          {7'h??, 3'b000}: ctrl.alu_op = AluAdd;
          {7'h00, 3'b001}: ctrl.alu_op = AluSll;
          {7'h00, 3'b101}: ctrl.alu_op = AluSrl;
          {7'h20, 3'b101}: ctrl.alu_op = AluSra;
          default:         bad = 1'b1;
        endcase
      end
      OpcOp32: begin
        ctrl.we_regs = 1'b1; ctrl.is_word = 1'b1; bad = !WordEn;
        case ({f7, f3})
          {7'h00, 3'b000}: ctrl.alu_op = AluAdd;
          {7'h20, 3'b000}: ctrl.alu_op = AluSub;
          {7'h00, 3'b001}: ctrl.alu_op = AluSll;
          {7'h00, 3'b101}: ctrl.alu_op = AluSrl;
          {7'h20, 3'b101}: ctrl.alu_op = AluSra;
          default:         bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl         = '0;
      ctrl.alu_op  = AluNop;
      ctrl.rd      = rd_f;
      ctrl.func3   = f3;
      ctrl.illegal = 1'b1;
      use_imm      = 1'b0;
      a_pc         = 1'b0;
    end
  end

  // Assemble the bundle from the decode and the same-cycle register-file data.
  always_comb begin
    bundle_d         = '0;
    bundle_d.pc      = in_pc;
    bundle_d.imm     = imm;
    bundle_d.op_a    = a_pc ? in_pc : rd1;
    bundle_d.op_b    = use_imm ? imm : rd2;
    bundle_d.rs2_val = rd2;
    bundle_d.ctrl    = ctrl;
  end

  // Output register: load on accept, bubble on advance without accept, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q            <= 1'b0;
      bundle_q               <= '0;
      bundle_q.ctrl.alu_op   <= AluNop;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (advance) begin
      out_valid_q <= in_valid && in_ready;
      if (in_valid && in_ready) bundle_q <= bundle_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = bundle_q.pc;
  assign out_imm       = bundle_q.imm;
  assign out_op_a      = bundle_q.op_a;
  assign out_op_b      = bundle_q.op_b;
  assign out_rs2_val   = bundle_q.rs2_val;
  assign out_alu_op    = bundle_q.ctrl.alu_op;
  assign out_rd        = bundle_q.ctrl.rd;
  assign out_we_regs   = bundle_q.ctrl.we_regs;
  assign out_we_mem    = bundle_q.ctrl.we_mem;
  assign out_is_load   = bundle_q.ctrl.is_load;
  assign out_is_jalr   = bundle_q.ctrl.is_jalr;
  assign out_is_jal    = bundle_q.ctrl.is_jal;
  assign out_is_branch = bundle_q.ctrl.is_branch;
  assign out_is_word   = bundle_q.ctrl.is_word;
  assign out_illegal   = bundle_q.ctrl.illegal;
  assign out_func3     = bundle_q.ctrl.func3;
  assign out_be        = bundle_q.ctrl.be;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised successor to the combinational instruction decoder: one pipeline stage between fetch and execute for RV32I/RV64I. It decodes the incoming instruction, reads operands through the register-file read ports, and registers a decoded bundle behind a valid/ready handshake. It adds RV64 word ops, illegal-instruction detection, load-use stall insertion and flush.

## Interface

- XLEN, 64, datapath width; legal values 32 or 64.
- EN_WORD_OPS, 1, enables OP-32/OP-IMM-32 and LD/LWU/SD; forced to 0 when XLEN=32.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  drops the held instruction and the stall; wins over everything except rst.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- rs1, rs2  out  5  register-file read addresses, combinational from in_instr; 0 when the format has no such field.
- rd1, rd2  in  XLEN  register-file read data, same cycle.
- out_valid  out  1  decoded bundle is valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc, out_imm, out_op_a, out_op_b  out  XLEN  pc, sign-extended immediate, rs1 value, ALU B operand (imm or rd2).
- out_rs2_val  out  XLEN  rd2, kept for stores and branches.
- out_alu_op  out  4  ALU opcode.
- out_rd  out  5  destination register.
- out_we_regs, out_we_mem, out_is_load, out_is_jalr, out_is_jal, out_is_branch, out_is_word, out_illegal  out  1 each  control flags.
- out_func3  out  3  raw func3, used for branch condition and load sign/size.
- out_be  out  8  byte enable for stores and loads: B 0x01, H 0x03, W 0x0F, D 0xFF.

## Operation

- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0101, NOP 1010, SLT 1011, SLTU 1100, SLL 1101, SRL 1110, SRA 1111.
- Loads, stores, LUI, AUIPC, JAL and JALR use ADD. Branches use ADD and are resolved in execute, not here.
- Immediate formats:
  - I, S, B, U and J formats are sign-extended to XLEN.
  - U-format immediates are {instr[31:12], 12'b0} sign-extended from bit 31.
- Shift amounts:
  - XLEN=64: shamt is instr[25:20]; SRAI is selected by instr[31:26]=6'b010000.
  - XLEN=32, and all W ops: shamt is instr[24:20], and instr[25] must be 0.
- out_is_word=1 for OP-32 (0111011) and OP-IMM-32 (0011011): ADDW, SUBW, SLLW, SRLW, SRAW, ADDIW, SLLIW, SRLIW, SRAIW. Any other func field combination is illegal.
- Illegal conditions:
  - unknown opcode;
  - unknown func3/func7 combination;
  - load func3 011 or 110, or store func3 011, when EN_WORD_OPS=0;
  - load func3 111, or store func3 1xx;
  - branch func3 010 or 011.
- An illegal instruction still passes through with out_valid=1 and out_illegal=1, with we_regs=0, we_mem=0, all other flags 0 and alu_op NOP.
- Writes to rd=0 keep we_regs as decoded; the register file ignores them.
- Load-use hazard:
  - Condition: out_valid & out_is_load & out_rd≠0 & (out_rd==rs1 or out_rd==rs2), counting only source fields the incoming format actually uses.
  - Effect: in_ready=0; if the output register advances, a bubble is loaded (out_valid=0).

## Timing

- Latency is 1 cycle from acceptance (in_valid & in_ready) to out_valid.
- advance = ~out_valid | out_ready.
- in_ready = advance & ~hazard & ~flush (combinational).
- On advance:
  - the bundle is loaded from the input when in_valid & in_ready;
  - otherwise out_valid becomes 0.
- When not advancing, every output holds stable; the bundle must not change while out_valid & ~out_ready.
- flush: the next cycle has out_valid=0; the input is not accepted in the flush cycle.
- Reset: out_valid=0, all bundle fields 0, out_alu_op=1010. Reset mid-transfer discards the held bundle.
- No combinational path exists from out_ready to any out_* field. The out_ready→in_ready path is allowed.

## Structure

- Shared package riscv_pkg: opcode constants, ALU opcode constants, byte-enable constants, and a packed struct for the decoded bundle, parametrised by XLEN through a localparam in the stage.
- Sub-module imm_gen: combinational, takes instr and produces the XLEN-wide immediate plus the format type. It is reused later by fetch branch prediction.
- The stage itself holds the field decode, illegal check, hazard logic and output register.

## Test plan

- XLEN=64, in_instr=0x00500093 (addi x1,x0,5), out_ready=1 → next cycle out_valid=1, alu_op=0000, rd=1, out_imm=5, we_regs=1.
- ld x5,0(x2), then add x6,x5,x1 back-to-back → add held for one cycle (in_ready=0), one bubble, then add issued; no stall if the second instruction uses x7 instead.
- XLEN=32 with in_instr=0x0000B083 (ld) → out_illegal=1, we_regs=0; with XLEN=64 the same word decodes as a legal load with be=0xFF.
- out_ready=0 for 3 cycles with valid bundle sw x3,8(x4) → bundle stable and in_ready=0 throughout; be=0x0F, we_mem=1.
- flush asserted while a bundle is held and in_valid=1 → next cycle out_valid=0 and the input is not consumed; rst mid-stall → out_valid=0, alu_op=1010.
- sraiw x1,x2,3 (0x4031509B) → out_is_word=1, alu_op=1111, out_imm[4:0]=3; the same encoding with instr[25]=1 → illegal.
